// File: rtl/score_to_bcd_signed.sv
// score_to_bcd_signed: signed score to sign + 3 BCD digits via an iterative double-dabble engine.
module score_to_bcd_signed #(
    parameter int W    = 10,
    parameter int MAXV = 999
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] val,
    output logic         busy,
    output logic         done,
    output logic         neg,
    output logic [3:0]   hundreds,
    output logic [3:0]   tens,
    output logic [3:0]   ones,
    output logic         ovf
);
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
    localparam logic [3:0] MAX_H = 4'((MAXV / 100) % 10);
    localparam logic [3:0] MAX_T = 4'((MAXV / 10) % 10);
    localparam logic [3:0] MAX_O = 4'(MAXV % 10);
    state_t state, state_n;
    logic [W-1:0] mag;
    logic sgn;
    logic [19:0] scr, scr_adj;
    logic [4:0] cnt;
    logic [16:0] scr_bin;
    assign busy = state != IDLE;
    always_comb begin
        state_n = (state == IDLE && start) ? SHIFT :
                  (state == SHIFT && cnt == 5'(W - 1)) ? FIN :
                  (state == FIN) ? IDLE : state;
    end
    always_comb begin
        scr_adj = scr;
        for (int i = 0; i < 5; i++)
            scr_adj[4*i +: 4] = (scr[4*i +: 4] >= 4'd5) ? scr[4*i +: 4] + 4'd3 : scr[4*i +: 4];
    end
    // binary value of the scratch, only used for the saturation compare
    assign scr_bin = 17'(scr[19:16]) * 17'd10000 + 17'(scr[15:12]) * 17'd1000 +
                     17'(scr[11:8]) * 17'd100 + 17'(scr[7:4]) * 17'd10 + 17'(scr[3:0]);
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            mag      <= '0;
            sgn      <= 1'b0;
            scr      <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            if (state == IDLE && start) begin
                mag <= val[W-1] ? -val : val;
                sgn <= val[W-1] && (val != '0);
                scr <= '0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                {scr, mag} <= {scr_adj[18:0], mag, 1'b0};
                cnt        <= cnt + 5'd1;
            end else if (state == FIN) begin
                ovf      <= scr_bin > 17'(MAXV);
                hundreds <= (scr_bin > 17'(MAXV)) ? MAX_H : scr[11:8];
                tens     <= (scr_bin > 17'(MAXV)) ? MAX_T : scr[7:4];
                ones     <= (scr_bin > 17'(MAXV)) ? MAX_O : scr[3:0];
                neg      <= sgn;
                done     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_score_to_bcd_signed.sv
// tb_score_to_bcd_signed: scoreboard bench for score_to_bcd_signed at W=10 and W=12.
module tb_score_to_bcd_signed;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [9:0] val_a = '0;
    logic [11:0] val_b = '0;
    logic busy_a, done_a, neg_a, ovf_a, busy_b, done_b, neg_b, ovf_b;
    logic [3:0] h_a, t_a, o_a, h_b, t_b, o_b;
    logic [14:0] q_a[$], q_b[$];
    int total = 0, bad = 0;

    score_to_bcd_signed #(.W(10), .MAXV(999)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .val(val_a), .busy(busy_a), .done(done_a),
        .neg(neg_a), .hundreds(h_a), .tens(t_a), .ones(o_a), .ovf(ovf_a));
    score_to_bcd_signed #(.W(12), .MAXV(999)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .val(val_b), .busy(busy_b), .done(done_b),
        .neg(neg_b), .hundreds(h_b), .tens(t_b), .ones(o_b), .ovf(ovf_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every done pulse pops one expected {neg,ovf,h,t,o}
    always @(negedge clk) begin
        if (done_a) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done_a: got done with no pending conversion");
            end else chk("result_a", 32'({neg_a, ovf_a, h_a, t_a, o_a}), 32'(q_a.pop_front()));
        end
        if (done_b) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done_b: got done with no pending conversion");
            end else chk("result_b", 32'({neg_b, ovf_b, h_b, t_b, o_b}), 32'(q_b.pop_front()));
        end
    end

    task automatic run(input bit b, input logic [11:0] v, input logic [14:0] e, input bit inj);
        int k = 0;
        int busy_bad = 0;
        bit seen = 1'b0;
        @(negedge clk);
        if (b) begin start_b = 1'b1; val_b = v; q_b.push_back(e); end
        else begin start_a = 1'b1; val_a = v[9:0]; q_a.push_back(e); end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        while (!seen && k < 60) begin
            if (b ? done_b : done_a) seen = 1'b1;
            else begin
                if (!(b ? busy_b : busy_a)) busy_bad++;
                if (inj && k == 4) begin start_a = 1'b1; val_a = ~v[9:0]; end
                if (inj && k == 5) begin start_a = 1'b0; val_a = v[9:0]; end
                @(negedge clk);
                k++;
            end
        end
        chk("latency", 32'(k), b ? 32'd13 : 32'd11);
        chk("busy_during", 32'(busy_bad), 32'd0);
        chk("busy_at_done", 32'(b ? busy_b : busy_a), 32'd0);
    endtask

    initial begin
        int pos[$];
        int k;
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_a", 32'({busy_a, done_a, neg_a, ovf_a, h_a, t_a, o_a}), 32'd0);
        chk("reset_b", 32'({busy_b, done_b, neg_b, ovf_b, h_b, t_b, o_b}), 32'd0);
        start_a = 1'b0;
        start_b = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_a", 32'({busy_a, done_a, neg_a, ovf_a, h_a, t_a, o_a}), 32'd0);

        run(0, 12'd237, {2'b00, 12'h237}, 0);
        run(0, 12'hE00, {2'b10, 12'h512}, 0);
        run(0, 12'hFFF, {2'b10, 12'h001}, 0);
        run(0, 12'd0,   {2'b00, 12'h000}, 0);
        run(0, 12'd511, {2'b00, 12'h511}, 0);
        run(0, 12'd123, {2'b00, 12'h123}, 1);
        repeat (15) @(negedge clk);
        chk("held_after_ignored_start", 32'({neg_a, ovf_a, h_a, t_a, o_a}), 32'({2'b00, 12'h123}));

        // start held for 40 edges: four conversions of -7
        @(negedge clk);
        start_a = 1'b1;
        val_a = 10'h3F9;
        repeat (4) q_a.push_back({2'b10, 12'h007});
        @(negedge clk);
        for (k = 0; k < 60; k++) begin
            if (done_a) pos.push_back(k);
            if (k == 39) start_a = 1'b0;
            @(negedge clk);
        end
        chk("b2b_count", 32'(pos.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("b2b_pos", (i < pos.size()) ? 32'(pos[i]) : 32'hFFFF, 32'(11 + 12 * i));

        // reset at edge E+5 of a -45 conversion
        @(negedge clk);
        start_a = 1'b1;
        val_a = 10'h3D3;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midreset_a", 32'({busy_a, done_a, neg_a, ovf_a, h_a, t_a, o_a}), 32'd0);
        k = 0;
        repeat (20) begin @(negedge clk); if (done_a) k++; end
        chk("midreset_no_done", 32'(k), 32'd0);
        chk("midreset_held", 32'({neg_a, ovf_a, h_a, t_a, o_a}), 32'd0);

        run(1, 12'h830, {2'b11, 12'h999}, 0);
        run(1, 12'd999, {2'b00, 12'h999}, 0);
        k = 0;
        repeat (20) begin
            @(negedge clk);
            if ({busy_b, done_b, neg_b, ovf_b, h_b, t_b, o_b} !== {4'b0000, 12'h999}) k++;
        end
        chk("held_idle_b", 32'(k), 32'd0);
        chk("queues_empty", 32'(q_a.size() + q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1);
    end
endmodule
